// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle layout, register-zero constant
// and the packed control struct used by the ID/EX, EX/MEM and MEM/WB registers.
package mips_pipe_pkg;

  localparam int CTRL_W = 10;

  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_ALU_OP_HI  = 3;
  localparam int CTRL_ALU_OP_LO  = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field order matches the bit-index constants above (MSB first).
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use hazard detector and PC / IF-ID write-enable generation.
// Hold outranks flush, and flush outranks a detected hazard.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             load_use_stall
);

  logic rs_match;
  logic rt_match;
  logic hazard;

  // $0 is hard-wired, so a load targeting it can never feed a consumer.
  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rt);
    rt_match = id_uses_rt && (id_rt == ex_rt);
    hazard   = ex_mem_read && ex_valid && (ex_rt != REG_W'(REG_ZERO))
               && (rs_match || rt_match);
  end

  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    load_use_stall = 1'b0;
    if (ex_hold) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end else if (flush) begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
    end else if (hazard) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      load_use_stall = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with merged load-use bubble insertion, branch flush and hold.
// Optional macro ID_EX_STALL_COUNT_EN adds a saturating stall_count output.
module id_ex_hazard_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              flush,
  input  logic              ex_hold,
  output logic [REG_W-1:0]  Rs_lv2,
  output logic [REG_W-1:0]  Rt_lv2,
  output logic [REG_W-1:0]  Rd_lv2,
  output logic [DATA_W-1:0] ReadData1_lv2,
  output logic [DATA_W-1:0] ReadData2_lv2,
  output logic [DATA_W-1:0] Imm_lv2,
  output logic [CTRL_W-1:0] ctrl_lv2,
  output logic              valid_lv2,
  output logic              pc_write_en,
  output logic              ifid_write_en,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [15:0]       stall_count,
`endif
  output logic              load_use_stall
);

  logic ex_mem_read;

  assign ex_mem_read = ctrl_is_load(ctrl_lv2);

  load_use_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .ex_mem_read    (ex_mem_read),
    .ex_valid       (valid_lv2),
    .ex_rt          (Rt_lv2),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .flush          (flush),
    .ex_hold        (ex_hold),
    .pc_write_en    (pc_write_en),
    .ifid_write_en  (ifid_write_en),
    .load_use_stall (load_use_stall)
  );

  // Operand fields still load on a bubble; only ctrl/valid must be squashed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Rs_lv2        <= '0;
      Rt_lv2        <= '0;
      Rd_lv2        <= '0;
      ReadData1_lv2 <= '0;
      ReadData2_lv2 <= '0;
      Imm_lv2       <= '0;
      ctrl_lv2      <= '0;
      valid_lv2     <= 1'b0;
    end else if (ex_hold) begin
      Rs_lv2        <= Rs_lv2;
      Rt_lv2        <= Rt_lv2;
      Rd_lv2        <= Rd_lv2;
      ReadData1_lv2 <= ReadData1_lv2;
      ReadData2_lv2 <= ReadData2_lv2;
      Imm_lv2       <= Imm_lv2;
      ctrl_lv2      <= ctrl_lv2;
      valid_lv2     <= valid_lv2;
    end else if (flush) begin
      Rs_lv2        <= '0;
      Rt_lv2        <= '0;
      Rd_lv2        <= '0;
      ReadData1_lv2 <= '0;
      ReadData2_lv2 <= '0;
      Imm_lv2       <= '0;
      ctrl_lv2      <= '0;
      valid_lv2     <= 1'b0;
    end else begin
      Rs_lv2        <= id_rs;
      Rt_lv2        <= id_rt;
      Rd_lv2        <= id_rd;
      ReadData1_lv2 <= id_rd1;
      ReadData2_lv2 <= id_rd2;
      Imm_lv2       <= id_imm;
      if (load_use_stall) begin
        ctrl_lv2  <= '0;
        valid_lv2 <= 1'b0;
      end else begin
        ctrl_lv2  <= id_ctrl;
        valid_lv2 <= 1'b1;
      end
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [15:0] stall_count_q;

  // load_use_stall is already masked by hold and flush, so it is the only qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (load_use_stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
